// File: rtl/c_expand_stage.sv
// c_expand_stage
// Decode-side stage behind the misalignment realigner. Each fetch word is
// either a 32-bit instruction (passed through unchanged) or an RV32C 16-bit
// instruction in inst_in[15:0], which is expanded to its RV32I equivalent.
// The result, with its PC and flags, goes into a 2-entry skid buffer. Entry M
// drives the outputs. Entry S holds a word that was accepted while M was
// stalled.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   sel_for_branch      flush: drop buffered and incoming words this cycle
//   in_valid/in_ready   upstream handshake
//   pc_in, inst_in      PC and fetch word; compressed iff inst_in[1:0]!=2'b11
//   pc_misaligned_i     realigner flag, carried alongside the word
//   out_valid/out_ready decoder handshake
//   out_pc, out_pc_next PC and sequential next PC (+2 compressed, +4 otherwise)
//   out_inst            32-bit instruction (NOP_INST while out_valid=0)
//   out_is_compressed   source word was 16-bit
//   out_illegal         reserved/unsupported compressed encoding
//   out_misaligned      registered copy of pc_misaligned_i
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is a pure register output (!S.valid) with no path from
// out_ready. out_* fields stay stable while out_valid=1 and out_ready=0.
// sel_for_branch overrides both sides: nothing is accepted, and both entries
// are empty after the edge.
module c_expand_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_for_branch,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        pc_misaligned_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_next,
  output logic [31:0] out_inst,
  output logic        out_is_compressed,
  output logic        out_illegal,
  output logic        out_misaligned
);

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        comp;
    logic        ill;
    logic        mis;
  } entry_t;

  // Expander
  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [19:0] j_imm;      // J-type immediate field bits [31:12]
  logic [31:0] exp_inst;
  logic        exp_ill;
  logic [2:0]  alu_f3;
  logic        is_comp;

  assign c       = inst_in[15:0];
  assign is_comp = (inst_in[1:0] != 2'b11);
  assign rd      = c[11:7];
  assign rs2     = c[6:2];
  assign rdp     = {2'b01, c[4:2]};
  assign rs1p    = {2'b01, c[9:7]};
  // c.jal/c.j offset scrambled into the jal layout imm[20|10:1|11|19:12]
  assign j_imm   = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                    c[12], {8{c[12]}}};

  always_comb begin
    exp_inst = {16'h0000, c};
    exp_ill  = 1'b0;
    alu_f3   = 3'b000;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: begin // c.addi4spn
            exp_ill  = (c[12:5] == 8'h00);
            exp_inst = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, OP_IMM};
          end
          3'b010: exp_inst = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, OP_LOAD};
          3'b110: exp_inst = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, OP_STORE};
          default: exp_ill = 1'b1; // FP loads/stores and reserved
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: exp_inst = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, OP_IMM};
          3'b001: exp_inst = {j_imm, 5'd1, OP_JAL};
          3'b010: exp_inst = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, OP_IMM};
          3'b011: begin
            exp_ill = ({c[12], c[6:2]} == 6'h00);
            if (rd == 5'd2) // c.addi16sp
              exp_inst = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, OP_IMM};
            else            // c.lui
              exp_inst = {{15{c[12]}}, c[6:2], rd, OP_LUI};
          end
          3'b100: begin
            case (c[11:10])
              2'b00: begin
                exp_ill  = c[12];
                exp_inst = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
              end
              2'b01: begin
                exp_ill  = c[12];
                exp_inst = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
              end
              2'b10: exp_inst = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                // c[12]=1 selects the RV64-only subw/addw group
                exp_ill = c[12];
                case (c[6:5])
                  2'b00:   alu_f3 = 3'b000;
                  2'b01:   alu_f3 = 3'b100;
                  2'b10:   alu_f3 = 3'b110;
                  default: alu_f3 = 3'b111;
                endcase
                exp_inst = {(c[6:5] == 2'b00) ? 7'b0100000 : 7'b0000000, rdp, rs1p, alu_f3, rs1p, OP_REG};
              end
            endcase
          end
          3'b101: exp_inst = {j_imm, 5'd0, OP_JAL};
          default: // c.beqz / c.bnez; c[13] picks funct3 000 vs 001
            exp_inst = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, {2'b00, c[13]}, c[11:10], c[4:3], c[12], OP_BRANCH};
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: begin
            exp_ill  = c[12];
            exp_inst = {7'b0000000, c[6:2], rd, 3'b001, rd, OP_IMM};
          end
          3'b010: begin
            exp_ill  = (rd == 5'd0);
            exp_inst = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, OP_LOAD};
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin // c.jr
                exp_ill  = (rd == 5'd0);
                exp_inst = {12'h000, rd, 3'b000, 5'd0, OP_JALR};
              end else begin         // c.mv
                exp_inst = {7'b0, rs2, 5'd0, 3'b000, rd, OP_REG};
              end
            end else begin
              if (rs2 == 5'd0) begin
                if (rd == 5'd0) exp_inst = 32'h0010_0073; // c.ebreak
                else            exp_inst = {12'h000, rd, 3'b000, 5'd1, OP_JALR};
              end else begin         // c.add
                exp_inst = {7'b0, rs2, rd, 3'b000, rd, OP_REG};
              end
            end
          end
          3'b110: exp_inst = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, OP_STORE};
          default: exp_ill = 1'b1; // FP SP-relative forms
        endcase
      end
      default: exp_ill = 1'b0; // 32-bit word, expander output unused
    endcase
    // Illegal encodings hand the raw halfword to the decoder for trap info
    if (exp_ill) exp_inst = {16'h0000, c};
  end

  entry_t new_e;
  assign new_e = '{pc:   pc_in,
                   inst: is_comp ? exp_inst : inst_in,
                   comp: is_comp,
                   ill:  is_comp & exp_ill,
                   mis:  pc_misaligned_i};

  // Skid buffer
  entry_t m_e, s_e;
  logic   m_valid, s_valid;
  logic   accept;

  assign in_ready = !s_valid;
  assign accept   = in_valid && !s_valid && !sel_for_branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_e     <= '0;
      s_e     <= '0;
    end else if (sel_for_branch) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || out_ready) begin
      // M is free this cycle: refill from S first to keep order
      if (s_valid) begin
        m_e     <= s_e;
        m_valid <= 1'b1;
        s_valid <= accept;
        if (accept) s_e <= new_e;
      end else begin
        m_valid <= accept;
        if (accept) m_e <= new_e;
      end
    end else if (accept) begin
      s_e     <= new_e;
      s_valid <= 1'b1;
    end
  end

  assign out_valid         = m_valid;
  assign out_pc            = m_valid ? m_e.pc : RESET_PC;
  assign out_pc_next       = m_valid ? (m_e.pc + (m_e.comp ? 32'd2 : 32'd4)) : RESET_PC;
  assign out_inst          = m_valid ? m_e.inst : NOP_INST;
  assign out_is_compressed = m_valid & m_e.comp;
  assign out_illegal       = m_valid & m_e.ill;
  assign out_misaligned    = m_valid & m_e.mis;

endmodule
